// File: rtl/hmac_tag_tx.sv
// hmac_tag_tx: transmit-side HMAC-SHA1 framer.
// The message is written into a FIFO and handed to the external HMAC engine
// in the same cycle. The FIFO drains to the master stream while the engine
// works. After the last message word, the 160-bit digest is emitted as tag
// words H0..H4, and t_last is asserted on H4.
// Optional feature: define HMAC_TX_LEN_CNT_EN to add the msg_len output.
// msg_len is the word count of the last completed frame.
module hmac_tag_tx #(
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_t_valid,
  input  logic          s_t_last,
  input  logic [31:0]   s_t_data,
  output logic          s_t_ready,
  output logic          eng_valid,
  output logic          eng_last,
  output logic [31:0]   eng_data,
  input  logic          eng_ready,
  input  logic          digest_valid,
  input  logic [159:0]  digest,
  output logic          m_t_valid,
  output logic          m_t_last,
  output logic [31:0]   m_t_data,
  input  logic          m_t_ready,
  output logic          busy
`ifdef HMAC_TX_LEN_CNT_EN
  ,output logic [15:0]  msg_len
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_WAIT_DIG = 2'd1,
    ST_TAG      = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic [31:0]    mem_q [DEPTH];
  logic           dig_ok_q, dig_ok_d;
  logic [159:0]   tag_q, tag_d;
  logic [2:0]     cnt_q, cnt_d;

  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           m_hs;
  logic [31:0]    tag_word;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Select the tag word that the counter points at. H0 is the most significant word.
  always_comb begin
    tag_word = 32'd0;
    case (cnt_q)
      3'd0:    tag_word = tag_q[159:128];
      3'd1:    tag_word = tag_q[127:96];
      3'd2:    tag_word = tag_q[95:64];
      3'd3:    tag_word = tag_q[63:32];
      3'd4:    tag_word = tag_q[31:0];
      default: tag_word = 32'd0;
    endcase
  end

  // Stream-facing outputs.
  // The slave side is open only in LOAD. The master shows the tag in TAG, and otherwise shows the FIFO head.
  always_comb begin
    s_t_ready = 1'b0;
    eng_valid = 1'b0;
    eng_data  = s_t_data;
    eng_last  = s_t_last;
    m_t_valid = 1'b0;
    m_t_last  = 1'b0;
    m_t_data  = 32'd0;
    if (state_q == ST_LOAD) begin
      s_t_ready = eng_ready & ~fifo_full;
      eng_valid = s_t_valid & ~fifo_full;
    end else begin
      s_t_ready = 1'b0;
      eng_valid = 1'b0;
    end
    if (state_q == ST_TAG) begin
      m_t_valid = 1'b1;
      m_t_last  = (cnt_q == 3'd4);
      m_t_data  = tag_word;
    end else if (!fifo_empty) begin
      m_t_valid = 1'b1;
      m_t_data  = mem_q[rd_ptr_q[AW-1:0]];
    end else begin
      m_t_valid = 1'b0;
    end
  end

  assign busy = (state_q != ST_LOAD) || !fifo_empty;
  assign push = s_t_valid & s_t_ready;
  assign m_hs = m_t_valid & m_t_ready;
  assign pop  = m_hs & (state_q != ST_TAG);

  // Next-state logic for the pointers, the digest capture, the tag counter and the FSM.
  // WAIT_DIG moves to TAG when the FIFO will be empty after this cycle, so H0 follows the last message word with no gap.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dig_ok_d = dig_ok_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case (state_q)
      ST_LOAD: begin
        if (push && s_t_last) begin
          state_d = ST_WAIT_DIG;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_WAIT_DIG: begin
        if (digest_valid) begin
          dig_ok_d = 1'b1;
          tag_d    = digest;
        end else begin
          dig_ok_d = dig_ok_q;
        end
        if (dig_ok_d && (wr_ptr_d == rd_ptr_d)) begin
          state_d = ST_TAG;
        end else begin
          state_d = ST_WAIT_DIG;
        end
      end
      ST_TAG: begin
        if (m_hs) begin
          if (cnt_q == 3'd4) begin
            cnt_d    = 3'd0;
            dig_ok_d = 1'b0;
            state_d  = ST_LOAD;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Control registers. All of them clear at once on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dig_ok_q <= 1'b0;
      tag_q    <= 160'd0;
      cnt_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dig_ok_q <= dig_ok_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage. The pointers qualify its contents, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s_t_data;
    end
  end

`ifdef HMAC_TX_LEN_CNT_EN
  logic [15:0] len_cnt_q, len_cnt_d;
  logic [15:0] msg_len_q, msg_len_d;

  // Count the words of the current frame, saturating at 0xFFFF. Publish the count on the H4 handshake.
  always_comb begin
    len_cnt_d = len_cnt_q;
    msg_len_d = msg_len_q;
    if ((state_q == ST_TAG) && m_hs && (cnt_q == 3'd4)) begin
      msg_len_d = len_cnt_q;
      len_cnt_d = 16'd0;
    end else if (push && (len_cnt_q != 16'hFFFF)) begin
      len_cnt_d = len_cnt_q + 16'd1;
    end else begin
      len_cnt_d = len_cnt_q;
    end
  end

  // Registers for the length counter and the published length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_cnt_q <= 16'd0;
      msg_len_q <= 16'd0;
    end else begin
      len_cnt_q <= len_cnt_d;
      msg_len_q <= msg_len_d;
    end
  end

  assign msg_len = msg_len_q;
`endif

endmodule

// File: tb/tb_hmac_tag_tx.sv
// Bench for hmac_tag_tx. It drives random frames and compares the engine stream and the master stream against frame-level expectations.
// The master stream is expected to be the message words followed by the five digest words.
module tb_hmac_tag_tx;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_t_valid, s_t_last, s_t_ready;
  logic [31:0]  s_t_data;
  logic         eng_valid, eng_last, eng_ready;
  logic [31:0]  eng_data;
  logic         digest_valid;
  logic [159:0] digest;
  logic         m_t_valid, m_t_last, m_t_ready;
  logic [31:0]  m_t_data;
  logic         busy;
`ifdef HMAC_TX_LEN_CNT_EN
  logic [15:0]  msg_len;
`endif

  int n_vec = 0;
  int n_err = 0;

  hmac_tag_tx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_t_valid(s_t_valid), .s_t_last(s_t_last), .s_t_data(s_t_data), .s_t_ready(s_t_ready),
    .eng_valid(eng_valid), .eng_last(eng_last), .eng_data(eng_data), .eng_ready(eng_ready),
    .digest_valid(digest_valid), .digest(digest),
    .m_t_valid(m_t_valid), .m_t_last(m_t_last), .m_t_data(m_t_data), .m_t_ready(m_t_ready),
    .busy(busy)
`ifdef HMAC_TX_LEN_CNT_EN
    ,.msg_len(msg_len)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One frame of len words.
  // mr_hold: -1 holds m_t_ready high, 0 randomises it, >0 holds it low for that many cycles and then high.
  // er_mode: 0 randomises eng_ready, 1 holds it high, 2 toggles it.
  // abort_tag > 0 asserts reset after that many tag words have been accepted.
  task automatic run_frame(input int len, input int mr_hold, input int er_mode, input bit sv_always,
                           input int dig_dly, input bit gapless, input int abort_tag,
                           input bit full_chk, input bit fixed);
    logic [31:0]  words[$];
    logic [31:0]  exp_q[$];
    logic [159:0] dg;
    logic [31:0]  pd;
    int sent, out_seen, dcount, cyc, first_hs, last_hs;
    bit done, aborted, pv_hold;
    sent = 0; out_seen = 0; dcount = -1; cyc = 0; first_hs = -1; last_hs = -1;
    done = 1'b0; aborted = 1'b0; pv_hold = 1'b0; pd = 32'd0;
    for (int i = 0; i < len; i++) begin
      if (fixed) words.push_back(32'h11111111 * (i + 1));
      else       words.push_back($urandom);
    end
    if (fixed) dg = {32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hA4A4A4A4};
    else       dg = {$urandom, $urandom, $urandom, $urandom, $urandom};
    exp_q = words;
    for (int k = 4; k >= 0; k--) exp_q.push_back(dg[k*32 +: 32]);

    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      s_t_valid = (sent < len) && (sv_always || ($urandom_range(0, 3) != 0));
      s_t_data  = (sent < len) ? words[sent] : 32'd0;
      s_t_last  = (sent == len - 1);
      case (er_mode)
        0:       eng_ready = ($urandom_range(0, 3) != 0);
        1:       eng_ready = 1'b1;
        default: eng_ready = cyc[0];
      endcase
      if (mr_hold < 0)       m_t_ready = 1'b1;
      else if (mr_hold == 0) m_t_ready = ($urandom_range(0, 3) != 0);
      else                   m_t_ready = (cyc >= mr_hold);
      if (dcount == 0) begin
        digest_valid = 1'b1;
        digest       = dg;
      end else if (dcount < 0 && sent < len && $urandom_range(0, 7) == 0) begin
        // This pulse arrives while the DUT is still in LOAD, so the DUT must ignore it.
        digest_valid = 1'b1;
        digest       = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end else begin
        digest_valid = 1'b0;
      end
      if (dcount >= 0) dcount--;
      #1;
      check_val("hs_coincide", {31'd0, eng_valid & eng_ready}, {31'd0, s_t_valid & s_t_ready});
      if (pv_hold) begin
        check_val("hold_valid", {31'd0, m_t_valid}, 32'd1);
        check_val("hold_data", m_t_data, pd);
      end
      if (full_chk && cyc == 25) begin
        check_val("full_accepted", sent, DEPTH);
        check_val("full_s_ready", {31'd0, s_t_ready}, 32'd0);
        check_val("full_eng_valid", {31'd0, eng_valid}, 32'd0);
      end
      if (s_t_valid && s_t_ready) begin
        check_val("eng_data", eng_data, words[sent]);
        check_val("eng_last", {31'd0, eng_last}, {31'd0, sent == len - 1});
        sent++;
        if (sent == len) dcount = dig_dly;
      end
      if (m_t_valid && m_t_ready) begin
        check_val("m_data", m_t_data, exp_q[out_seen]);
        check_val("m_last", {31'd0, m_t_last}, {31'd0, out_seen == len + 4});
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        out_seen++;
        if (out_seen == len + 5) done = 1'b1;
      end
      pv_hold = m_t_valid & ~m_t_ready;
      pd      = m_t_data;
      if (abort_tag > 0 && out_seen == len + abort_tag) begin
        rst_n = 1'b0;
        s_t_valid = 1'b0;
        digest_valid = 1'b0;
        #1;
        check_val("rst_m_valid", {31'd0, m_t_valid}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_s_ready", {31'd0, s_t_ready}, {31'd0, eng_ready});
`ifdef HMAC_TX_LEN_CNT_EN
        check_val("rst_msg_len", {16'd0, msg_len}, 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        aborted = 1'b1;
        done = 1'b1;
      end
      cyc++;
    end
    s_t_valid = 1'b0;
    digest_valid = 1'b0;
    if (!aborted) begin
      check_val("frame_done", {31'd0, done}, 32'd1);
      if (gapless) check_val("gapless_span", last_hs - first_hs, len + 4);
      @(posedge clk); #2;
      check_val("idle_busy", {31'd0, busy}, 32'd0);
      check_val("idle_m_valid", {31'd0, m_t_valid}, 32'd0);
`ifdef HMAC_TX_LEN_CNT_EN
      check_val("msg_len", {16'd0, msg_len}, len);
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s_t_valid = 1'b1; s_t_last = 1'b0; s_t_data = 32'h5A5A5A5A;
    eng_ready = 1'b1; digest_valid = 1'b0; digest = 160'd0; m_t_ready = 1'b1;
    #12;
    check_val("rst_s_ready", {31'd0, s_t_ready}, 32'd1);
    check_val("rst_eng_valid", {31'd0, eng_valid}, 32'd1);
    check_val("rst_m_valid", {31'd0, m_t_valid}, 32'd0);
    check_val("rst_m_last", {31'd0, m_t_last}, 32'd0);
    check_val("rst_m_data", m_t_data, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    eng_ready = 1'b0; s_t_valid = 1'b0;
    #1;
    check_val("rst_s_ready_lo", {31'd0, s_t_ready}, 32'd0);
    check_val("rst_eng_valid_lo", {31'd0, eng_valid}, 32'd0);
`ifdef HMAC_TX_LEN_CNT_EN
    check_val("rst_msg_len", {16'd0, msg_len}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed 3-word frame, with the digest arriving 4 cycles after the last word.
    run_frame(3, -1, 1, 1'b1, 3, 1'b0, 0, 1'b0, 1'b1);
    // Early digest: the FIFO holds 5 words when the tag is captured, and H0 must follow with no gap.
    run_frame(5, 12, 1, 1'b1, 1, 1'b1, 0, 1'b0, 1'b0);
    // Full FIFO: a 20-word message with the master blocked.
    run_frame(20, 30, 1, 1'b1, 2, 1'b1, 0, 1'b1, 1'b0);
    // The engine toggles its ready every cycle.
    run_frame(9, -1, 2, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
    // Single-word frame followed by a 7-word frame.
    run_frame(1, -1, 1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
    run_frame(7, 0, 0, 1'b0, 2, 1'b0, 0, 1'b0, 1'b0);
    // Reset during TAG after H1 has been sent, then a clean frame.
    run_frame(4, -1, 1, 1'b1, 0, 1'b0, 2, 1'b0, 1'b0);
    run_frame(6, 0, 0, 1'b0, 3, 1'b0, 0, 1'b0, 1'b0);
    // Random frames.
    for (int f = 0; f < 12; f++) begin
      run_frame($urandom_range(1, 24), 0, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                $urandom_range(0, 8), 1'b0, 0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hmac_tag_tx.md
# hmac_tag_tx

Transmit-side HMAC-SHA1 framer: accepts a message over an AXI-Stream slave, forwards each word to an external HMAC-SHA1 engine, and re-emits the message on an AXI-Stream master followed by the 5-word, 160-bit tag. Its output stream is the exact format the authenticating receiver expects: message words, then tag words H0..H4, with `t_last` on H4. It sits between the host DMA and the link, in front of the two-stage HMAC core.

## Interface
- `DEPTH`, 16: message FIFO depth in words; power of two, minimum 4.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `s_t_valid` input 1: slave word valid.
- `s_t_last` input 1: last message word.
- `s_t_data` input 32: message word.
- `s_t_ready` output 1: slave ready.
- `eng_valid` output 1: word valid to HMAC engine.
- `eng_last` output 1: last word to engine.
- `eng_data` output 32: word to engine.
- `eng_ready` input 1: engine accepts a word.
- `digest_valid` input 1: one-cycle pulse; digest is present.
- `digest` input 160: HMAC result; H0 = [159:128] … H4 = [31:0].
- `m_t_valid` output 1: master word valid.
- `m_t_last` output 1: asserted only on tag word H4.
- `m_t_data` output 32: message or tag word.
- `m_t_ready` input 1: downstream ready.
- `busy` output 1: high in any state other than LOAD with an empty FIFO.

## Operation
- FSM states: LOAD, WAIT_DIG, TAG. Reset state is LOAD.
- **LOAD**
  - `s_t_ready = eng_ready & ~fifo_full`.
  - `eng_valid = s_t_valid & ~fifo_full`. `eng_data` and `eng_last` pass `s_t_data` and `s_t_last` through combinationally.
  - A slave handshake writes the word into the FIFO and hands it to the engine in the same cycle.
  - A handshake with `s_t_last = 1` moves the FSM to WAIT_DIG.
- **WAIT_DIG**
  - `s_t_ready = 0`, `eng_valid = 0`.
  - A `digest_valid` pulse loads the 160-bit tag register and sets `dig_ok`.
  - Go to TAG when `dig_ok` is set and the FIFO is empty. This also covers a digest that arrived before the drain finished.
- **TAG**
  - Emits the tag register as H0, H1, H2, H3, H4, one word per master handshake, tracked by a 3-bit counter 0..4.
  - `m_t_last = 1` only on H4.
  - The H4 handshake clears `dig_ok` and the counter and returns the FSM to LOAD.
- **Message drain**
  - Independent of the FSM in LOAD and WAIT_DIG: whenever the FIFO is non-empty, `m_t_valid = 1` and `m_t_data` = FIFO head, with `m_t_last = 0`.
  - The incoming `s_t_last` is never forwarded on the master.
- **Ignored digest**: `digest_valid` outside WAIT_DIG is ignored; the tag register is unchanged.
- **Full FIFO**: push is blocked (`s_t_ready = 0`) even if a pop happens in the same cycle. Push and pop in the same cycle are allowed when the FIFO is not full.
- **Pointers**: FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and the rest are equal; empty = pointers equal.
- **Single-word message**: `s_t_last` on the first word is legal and gives a 6-word output frame.
- **Reset mid-frame**: all state, pointers, `dig_ok` and the counter clear immediately. No partial tag is emitted after reset; the engine is responsible for its own reset.

## Timing
- Reset values:
  - `s_t_ready` follows `eng_ready` (FIFO empty, LOAD).
  - `eng_valid` = `s_t_valid`.
  - `m_t_valid = 0`, `m_t_last = 0`, `m_t_data = 0`, `busy = 0`.
- Latency:
  - A word accepted at edge N is valid on the master from cycle N+1.
  - H0 is valid one cycle after the edge where both `dig_ok` = 1 and the FIFO is empty.
- Throughput: 1 word/cycle in both directions when ready is held high. Tag emission takes 5 cycles at full rate.
- Hold rule: `m_t_data`/`m_t_valid` stay stable while `m_t_valid & ~m_t_ready`.

## Configuration
- `HMAC_TX_LEN_CNT_EN`
  - **Defined**: adds output `msg_len[15:0]`, the number of message words in the last completed frame. It counts slave handshakes in LOAD, saturates at 0xFFFF, and is registered on the H4 handshake. Its reset value is 0.
  - **Undefined**: the port and counter are absent; all other behaviour is identical.

## Test plan
- **3-word frame**: message 0x11111111, 0x22222222, 0x33333333 (last); digest = {0xA0…, 0xA1…, 0xA2…, 0xA3…, 0xA4…} 4 cycles later; `m_t_ready = 1`.
  - Master emits the 3 message words then A0..A4, with `m_t_last` only on A4.
- **Early digest**: `digest_valid` arrives while the FIFO still holds 5 words because `m_t_ready = 0`.
  - The tag is captured; H0 follows the last message word with no gap once `m_t_ready = 1`.
- **Full FIFO**: DEPTH = 16, 20-word message, `m_t_ready = 0`.
  - `s_t_ready` drops after 16 words; `eng_valid` drops in the same cycle.
  - Releasing `m_t_ready` resumes the transfer; all 20 words are emitted in order.
- **Engine backpressure**: `eng_ready` toggles 1/0 every cycle.
  - Slave and engine handshakes coincide exactly; no word is duplicated or lost.
- **Reset mid-frame**: assert `rst_n = 0` during TAG after H1 has been sent.
  - `m_t_valid = 0` immediately; the next frame starts clean with a fresh tag.
- **Length counter** (macro defined): 1-word frame then 7-word frame.
  - `msg_len` reads 1 after the first H4 handshake and 7 after the second.
